// File: rtl/wb_demux_router.sv
// wb_demux_router: routes one valid/ready word stream to N_OUT channels,
// each buffered by a 2-entry FIFO so one stalled sink only blocks itself.
module wb_demux_router #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_OUT = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   drop_pulse
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [N_OUT][DEPTH];
    logic [CNT_W-1:0] cnt [N_OUT];
    logic [N_OUT-1:0] wptr;
    logic [N_OUT-1:0] rptr;

    logic [N_OUT-1:0] push_c;
    logic [N_OUT-1:0] pop_c;
    logic             sel_ok_c;

    // Destination decode; out-of-range selects are accepted and discarded.
    always_comb begin
        sel_ok_c = (32'(in_sel) < N_OUT);
    end

    // Ready/push decode. A full channel still accepts when its head pops this cycle.
    always_comb begin
        in_ready = 1'b1;
        push_c   = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_ready  = (cnt[k] != CNT_FULL) || out_ready[k];
                push_c[k] = in_valid && ((cnt[k] != CNT_FULL) || out_ready[k]);
            end
        end
    end

    // Pop decode and head presentation; ready on an empty channel is ignored.
    always_comb begin
        pop_c     = '0;
        out_valid = '0;
        out_data  = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_valid[k]               = (cnt[k] != CNT_EMPTY);
            pop_c[k]                   = (cnt[k] != CNT_EMPTY) && out_ready[k];
            out_data[k*WIDTH +: WIDTH] = mem[k][rptr[k]];
        end
    end

    // Per-channel FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                cnt[k] <= CNT_EMPTY;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem[k][e] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (push_c[k]) begin
                    mem[k][wptr[k]] <= in_data;
                    wptr[k]         <= ~wptr[k];
                end
                if (pop_c[k]) begin
                    rptr[k] <= ~rptr[k];
                end
                case ({push_c[k], pop_c[k]})
                    2'b10:   cnt[k] <= cnt[k] + CNT_W'(1);
                    2'b01:   cnt[k] <= cnt[k] - CNT_W'(1);
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    // One-cycle flag for a word accepted with an invalid destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= in_valid && !sel_ok_c;
        end
    end

endmodule

// File: tb/tb_wb_demux_router.sv
// Directed self-checking bench for wb_demux_router (WIDTH=32, N_OUT=3, SEL_W=2).
module tb_wb_demux_router;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned SEL_W = 2;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       in_sel;
    logic [WIDTH-1:0]       in_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   drop_pulse;

    int total;
    int bad;

    wb_demux_router #(
        .WIDTH (WIDTH),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] slice(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one edge with the given sink readiness, then idle.
    task automatic push(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data,
                        input logic [N_OUT-1:0] rdy);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_data   = data;
        out_ready = rdy;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data[63:0]), 64'h0);
        chk("rst_drop", 64'(drop_pulse), 64'h0);
        rst = 1'b0;
        step();

        // All destinations ready after reset, including the invalid one.
        for (int s = 0; s < 4; s++) begin
            in_sel = SEL_W'(s);
            #1;
            chk($sformatf("idle_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end
        chk("idle_data_hi", 64'(out_data[95:64]), 64'h0);

        // Single route to channel 1, drained the following cycle.
        in_sel = 2'd1;
        out_ready = 3'b111;
        #1;
        chk("route_ready", 64'(in_ready), 64'h1);
        push(2'd1, 32'hDEADBEEF, 3'b111);
        chk("route_valid", 64'(out_valid), 64'h2);
        chk("route_data", 64'(slice(1)), 64'hDEADBEEF);
        step();
        chk("route_drained", 64'(out_valid), 64'h0);

        // Fill channel 0, then full-buffer pass-through.
        push(2'd0, 32'h11, 3'b000);
        push(2'd0, 32'h22, 3'b000);
        in_sel = 2'd0;
        #1;
        chk("full_ready_sel0", 64'(in_ready), 64'h0);
        in_sel = 2'd2;
        #1;
        chk("full_ready_sel2", 64'(in_ready), 64'h1);
        chk("full_head", 64'(slice(0)), 64'h11);
        in_sel = 2'd0;
        out_ready = 3'b001;
        #1;
        chk("pass_ready", 64'(in_ready), 64'h1);
        push(2'd0, 32'h33, 3'b001);
        chk("order_v1", 64'(out_valid), 64'h1);
        chk("order_d1", 64'(slice(0)), 64'h22);
        step();
        chk("order_d2", 64'(slice(0)), 64'h33);
        chk("order_v2", 64'(out_valid), 64'h1);
        step();
        chk("order_empty", 64'(out_valid), 64'h0);

        // Simultaneous push and pop on channel 2 keeps count at 1.
        push(2'd2, 32'hA, 3'b000);
        chk("pp_pre_valid", 64'(out_valid), 64'h4);
        chk("pp_pre_data", 64'(slice(2)), 64'hA);
        push(2'd2, 32'hB, 3'b100);
        out_ready = 3'b000;
        #1;
        chk("pp_valid", 64'(out_valid), 64'h4);
        chk("pp_data", 64'(slice(2)), 64'hB);
        out_ready = 3'b100;
        step();
        out_ready = 3'b000;
        chk("pp_one_left", 64'(out_valid), 64'h0);

        // Invalid select is accepted, dropped, and flagged for one cycle.
        push(2'd1, 32'h66, 3'b000);
        in_sel = 2'd3;
        #1;
        chk("inv_ready", 64'(in_ready), 64'h1);
        push(2'd3, 32'h55, 3'b000);
        chk("inv_drop", 64'(drop_pulse), 64'h1);
        chk("inv_valid", 64'(out_valid), 64'h2);
        chk("inv_data", 64'(slice(1)), 64'h66);
        step();
        chk("inv_drop_off", 64'(drop_pulse), 64'h0);
        chk("inv_valid2", 64'(out_valid), 64'h2);
        out_ready = 3'b010;
        step();
        out_ready = 3'b000;
        chk("inv_cleanup", 64'(out_valid), 64'h0);

        // Reset mid-traffic flushes both filled channels.
        push(2'd0, 32'hA1, 3'b000);
        push(2'd0, 32'hA2, 3'b000);
        push(2'd1, 32'hB1, 3'b000);
        push(2'd1, 32'hB2, 3'b000);
        chk("mid_filled", 64'(out_valid), 64'h3);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data", 64'(out_data[63:0]), 64'h0);
        chk("mid_rst_drop", 64'(drop_pulse), 64'h0);
        step();
        rst = 1'b0;
        push(2'd1, 32'h77, 3'b000);
        out_ready = 3'b011;
        #1;
        chk("post_valid", 64'(out_valid), 64'h2);
        chk("post_data", 64'(slice(1)), 64'h77);
        step();
        chk("post_empty", 64'(out_valid), 64'h0);
        step();
        step();
        chk("post_stay_empty", 64'(out_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
